// File: rtl/serial_subtractor.sv
// serial_subtractor: {bout,diff} = a - b - bin, CHUNK bits per clock, valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a positive multiple of CHUNK");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [IW-1:0] idx;
  logic brw, last;
  logic [CHUNK:0] sub;
  // One extra bit so the borrow out of the chunk is never truncated.
  assign sub = {1'b0, ra[int'(idx)*CHUNK +: CHUNK]} - {1'b0, rb[int'(idx)*CHUNK +: CHUNK]} - {{CHUNK{1'b0}}, brw};
  assign last = idx == IW'(NCHUNK - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    nxt = state;
    if (state == IDLE && in_valid) nxt = CALC;
    else if (state == CALC && last) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      brw <= 1'b0;
      idx <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        ra <= a;
        rb <= b;
        brw <= bin;
        idx <= '0;
      end
      if (state == CALC) begin
        diff[int'(idx)*CHUNK +: CHUNK] <= sub[CHUNK-1:0];
        brw <= sub[CHUNK];
        idx <= idx + 1'b1;
        if (last) bout <= sub[CHUNK];
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
        if (last) ovf <= (ra[WIDTH-1] ^ rb[WIDTH-1]) & (sub[CHUNK-1] ^ ra[WIDTH-1]);
`endif
      end
    end
  end
endmodule
